// File: rtl/bcd_conv_sched.sv
// Shared binary-to-BCD converter (24-bit to 6 digits, shift-and-add-3) with round-robin requester scheduling.
// Optional macro BCD_CONV_SCHED_SAT_EN: saturate dout to 999999 when the operand exceeds 999999.
module bcd_conv_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [24*NCH-1:0] din,
  output logic [NCH-1:0]    ack,
  output logic [23:0]       dout,
  output logic [CHW-1:0]    dout_ch,
  output logic              dout_valid,
  output logic              ovf,
  output logic              busy
);

  // state | meaning
  // IDLE  | no conversion in progress; arbitrate on req
  // SHIFT | 24 shift-and-add-3 iterations, one per cycle
  // DONE  | result presented for one cycle with ack and dout_valid
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [23:0] MAX_DEC  = 24'd999999;
  localparam logic [4:0]  LAST_IT  = 5'd23;

  state_t         state, state_nx;
  logic [CHW-1:0] ptr, gnt_ch, cur_ch, ptr_nx;
  logic           gnt_any;
  logic [23:0]    din_sel;
  logic [23:0]    bin_sr, acc, acc_adj, acc_next, res_final;
  logic [4:0]     iter;
  logic           ovf_lat;

  // Iterate from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CHW'(idx);
      end
    end
  end

  always_comb begin
    int nx;
    nx     = (int'(gnt_ch) + 1) % NCH;
    ptr_nx = CHW'(nx);
  end

  assign din_sel = din[24*gnt_ch +: 24];

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < 6; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_next = {acc_adj[22:0], bin_sr[23]};
  end

`ifdef BCD_CONV_SCHED_SAT_EN
  assign res_final = ovf_lat ? 24'h999999 : acc_next;
`else
  assign res_final = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = SHIFT;
      SHIFT:   if (iter == LAST_IT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      cur_ch  <= '0;
      bin_sr  <= '0;
      acc     <= '0;
      iter    <= '0;
      ovf_lat <= 1'b0;
      dout    <= '0;
      dout_ch <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            bin_sr  <= din_sel;
            acc     <= '0;
            iter    <= '0;
            cur_ch  <= gnt_ch;
            ovf_lat <= (din_sel > MAX_DEC);
            ptr     <= ptr_nx;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= {bin_sr[22:0], 1'b0};
          iter   <= iter + 5'd1;
          // Result registers load on the last iteration so they are valid throughout DONE.
          if (iter == LAST_IT) begin
            dout    <= res_final;
            dout_ch <= cur_ch;
            ovf     <= ovf_lat;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == DONE) ack[cur_ch] = 1'b1;
  end

  assign dout_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: directed scenarios plus random requests against a cycle-level behavioural model.
module tb_bcd_conv_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;
`ifdef BCD_CONV_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [24*NCH-1:0] din = '0;
  logic [NCH-1:0]    ack;
  logic [23:0]       dout;
  logic [CHW-1:0]    dout_ch;
  logic              dout_valid, ovf, busy;

  bcd_conv_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack), .dout(dout),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    x = v % 1000000;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] exp_res(input logic [23:0] x);
    if (SAT && x > 24'd999999) return 24'h999999;
    return to_bcd(int'(x));
  endfunction

  // Model: phase counts down from 25 after a grant; phase 1 is the result cycle.
  int          phase, ptr_m, m_ch, p_ch, g;
  logic [23:0] m_dout, p_dout, sel;
  logic        m_ovf, p_ovf, found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; ptr_m = 0; m_dout = '0; m_ch = 0; m_ovf = 1'b0;
    end else if (phase > 0) begin
      phase--;
      if (phase == 1) begin
        m_dout = p_dout; m_ch = p_ch; m_ovf = p_ovf;
      end
    end else if (req != '0) begin
      found = 1'b0;
      g = 0;
      for (int i = 0; i < NCH; i++) begin
        if (!found && req[(ptr_m + i) % NCH]) begin
          found = 1'b1;
          g = (ptr_m + i) % NCH;
        end
      end
      sel    = din[24*g +: 24];
      p_ch   = g;
      p_dout = exp_res(sel);
      p_ovf  = (sel > 24'd999999);
      ptr_m  = (g + 1) % NCH;
      phase  = 25;
    end
  end

  always @(negedge clk) begin
    #1;
    check("busy", busy, phase != 0);
    check("dout_valid", dout_valid, phase == 1);
    check("ack", ack, (phase == 1) ? (32'd1 << m_ch) : 32'd0);
    check("dout", dout, m_dout);
    check("dout_ch", dout_ch, m_ch);
    check("ovf", ovf, m_ovf);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(input logic [23:0] exp_d, input int exp_c, input logic exp_o, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dout_valid && n < 60);
    if (!dout_valid) check("valid_timeout", 32'd0, 32'd1);
    else begin
      check("lit_dout", dout, exp_d);
      check("lit_ch", dout_ch, exp_c);
      check("lit_ovf", ovf, exp_o);
      check("lit_ack", ack, 32'd1 << exp_c);
    end
  endtask

  logic [23:0] vals [NCH];
  int n;

  initial begin
    repeat (3) step();
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_ack", ack, 0);
    rst_n = 1'b1;
    step();

    din[23:0] = 24'd123456;
    req = 4'b0001;
    wait_valid(24'h123456, 0, 1'b0, n);
    check("t1_latency", n, 25);
    req = '0;
    step();

    din[47:24] = 24'd0;
    req = 4'b0010;
    wait_valid(24'h000000, 1, 1'b0, n);
    din[47:24] = 24'd999999;
    wait_valid(24'h999999, 1, 1'b0, n);
    check("t2_spacing", n, 26);
    req = '0;
    step();
    check("t2_one_cycle", dout_valid, 0);

    din[95:72] = 24'd1000000;
    req = 4'b1000;
    wait_valid(SAT ? 24'h999999 : 24'h000000, 3, 1'b1, n);
    din[95:72] = 24'd16777215;
    wait_valid(SAT ? 24'h999999 : 24'h777215, 3, 1'b1, n);
    req = '0;
    step();

    for (int k = 0; k < NCH; k++) begin
      vals[k] = 24'($urandom_range(0, 999999));
      din[24*k +: 24] = vals[k];
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(exp_res(vals[k % NCH]), k % NCH, 1'b0, n);
      if (k > 0) check("rr_spacing", n, 26);
    end
    req = '0;
    step();

    req = 4'b0010;
    wait_valid(exp_res(vals[1]), 1, 1'b0, n);
    req = 4'b0011;
    wait_valid(exp_res(vals[0]), 0, 1'b0, n);
    req = '0;
    step();

    din[71:48] = 24'd654321;
    req = 4'b0100;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_dout", dout, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_valid", dout_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_valid(24'h654321, 2, 1'b0, n);
    check("post_rst_latency", n, 25);
    req = '0;
    step();

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NCH; k++)
        din[24*k +: 24] = ($urandom % 2 == 0) ? 24'($urandom_range(0, 999999)) : 24'($urandom);
      req = NCH'($urandom);
      repeat ($urandom_range(1, 40)) step();
    end
    req = '0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
